// File: rtl/gapu_pkg.sv
// -----------------------------------------------------------------------------
// gapu_pkg
// Shared constants and types for the GAPU result drain.
//   GA_DIM  : basis blades per multivector (one output beat per blade)
//   BLADE_W : blade index width
//   DATA_W  : coefficient width (FP32 bit pattern, never interpreted)
//   bank_state_t : life cycle of one ping-pong bank
// -----------------------------------------------------------------------------
package gapu_pkg;

  localparam int GA_DIM  = 32;
  localparam int BLADE_W = 5;
  localparam int DATA_W  = 32;

  localparam logic [1:0] BANK_EMPTY = 2'd0;
  localparam logic [1:0] BANK_FILL  = 2'd1;
  localparam logic [1:0] BANK_FULL  = 2'd2;
  localparam logic [1:0] BANK_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = BANK_EMPTY,
    ST_FILL  = BANK_FILL,
    ST_FULL  = BANK_FULL,
    ST_DRAIN = BANK_DRAIN
  } bank_state_t;

  // One-hot mask bit for a blade index.
  function automatic logic [GA_DIM-1:0] blade_onehot(input logic [BLADE_W-1:0] blade);
    logic [GA_DIM-1:0] oh;
    oh        = '0;
    oh[blade] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/gapu_result_drain_if.sv
// -----------------------------------------------------------------------------
// gapu_result_drain_if
// Bundles the core writeback port, the output beat stream and the sticky
// error flags of the result drain.
//   slave  : drain side (consumes writeback, produces the stream)
//   master : environment side (core + downstream sink)
// -----------------------------------------------------------------------------
interface gapu_result_drain_if;
  import gapu_pkg::*;

  // core writeback
  logic               wr_en;
  logic [BLADE_W-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_done;
  logic               wr_ready;
  // output stream
  logic               m_valid;
  logic               m_ready;
  logic [DATA_W-1:0]  m_data;
  logic [BLADE_W-1:0] m_blade;
  logic               m_last;
  // sticky status
  logic               err_incomplete;
  logic               err_overflow;

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, m_ready,
    output wr_ready, m_valid, m_data, m_blade, m_last,
           err_incomplete, err_overflow
  );

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, m_ready,
    input  wr_ready, m_valid, m_data, m_blade, m_last,
           err_incomplete, err_overflow
  );

endinterface

// File: rtl/gapu_result_bank.sv
// -----------------------------------------------------------------------------
// gapu_result_bank
// One ping-pong bank: GA_DIM x DATA_W storage, written-blade mask, and the
// EMPTY/FILL/FULL/DRAIN state machine. All controls arrive pre-qualified from
// the top (a strobe here means "this bank, and it is allowed").
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_wr_en/addr/data   : accepted coefficient write
//   i_wr_done           : accepted product close
//   i_drain_start       : FULL -> DRAIN
//   i_drain_end         : last beat accepted, DRAIN -> EMPTY
//   i_rd_addr           : blade to present on o_rd_data
//   o_state             : current bank state
//   o_close_complete    : mask including this cycle's write is all ones
//   o_rd_data           : stored coefficient, or 0 for an unwritten blade
// -----------------------------------------------------------------------------
module gapu_result_bank
  import gapu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_en,
  input  logic [BLADE_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]  i_wr_data,
  input  logic               i_wr_done,
  input  logic               i_drain_start,
  input  logic               i_drain_end,
  input  logic [BLADE_W-1:0] i_rd_addr,
  output bank_state_t        o_state,
  output logic               o_close_complete,
  output logic [DATA_W-1:0]  o_rd_data
);

  bank_state_t       r_state;
  bank_state_t       w_state_next;
  logic [GA_DIM-1:0] r_mask;
  logic [GA_DIM-1:0] w_mask_base;
  logic [GA_DIM-1:0] w_mask_wr;
  logic [DATA_W-1:0] r_mem [GA_DIM];

  // Storage is not reset: the mask alone decides what is valid, so a reset
  // (which clears the mask) discards contents without touching the array.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= i_drain_end ? '0 : w_mask_wr;
    end
  end

  always_comb begin
    // An EMPTY bank starts a fresh product, so its old mask never counts.
    w_mask_base = (r_state == ST_EMPTY) ? '0 : r_mask;
    w_mask_wr   = w_mask_base | (i_wr_en ? blade_onehot(i_wr_addr) : '0);

    w_state_next = r_state;
    unique case (r_state)
      ST_EMPTY: begin
        if (i_wr_done)    w_state_next = ST_FULL;
        else if (i_wr_en) w_state_next = ST_FILL;
      end
      ST_FILL:  if (i_wr_done)     w_state_next = ST_FULL;
      ST_FULL:  if (i_drain_start) w_state_next = ST_DRAIN;
      ST_DRAIN: if (i_drain_end)   w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  assign o_state          = r_state;
  assign o_close_complete = &w_mask_wr;
  assign o_rd_data        = r_mask[i_rd_addr] ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/gapu_result_drain.sv
// -----------------------------------------------------------------------------
// gapu_result_drain
// Captures the product core's blade-indexed result writeback into one of two
// banks and streams the finished multivector out as GA_DIM valid/ready beats
// (blade 0 first, m_last on the final blade). While one bank drains the core
// may fill the other.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, discards all buffered data
//   bus   : gapu_result_drain_if.slave (writeback, stream, error flags)
// -----------------------------------------------------------------------------
module gapu_result_drain
  import gapu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  gapu_result_drain_if.slave bus
);

  // bank selection and output register
  logic               r_fill_sel;
  logic               r_drain_sel;
  logic [BLADE_W-1:0] r_beat;       // index of the next beat to load
  logic               r_m_valid;
  logic [DATA_W-1:0]  r_m_data;
  logic [BLADE_W-1:0] r_m_blade;
  logic               r_m_last;
  logic               r_err_incomplete;
  logic               r_err_overflow;

  // per-bank wiring
  bank_state_t        w_state          [2];
  logic [DATA_W-1:0]  w_rd_data        [2];
  logic               w_close_complete [2];
  logic [BLADE_W-1:0] w_rd_addr        [2];
  logic [1:0]         w_bank_wr;
  logic [1:0]         w_bank_close;
  logic [1:0]         w_bank_dstart;
  logic [1:0]         w_bank_dend;

  logic w_fill_ok;
  logic w_wr_accept;
  logic w_close;
  logic w_fire;
  logic w_last_fire;
  logic w_chain;
  logic w_idle_start;
  logic w_idle_load;

  // Fill side: only an EMPTY/FILL bank takes writeback.
  assign w_fill_ok   = (w_state[r_fill_sel] == ST_EMPTY) || (w_state[r_fill_sel] == ST_FILL);
  assign w_wr_accept = bus.wr_en   && w_fill_ok;
  assign w_close     = bus.wr_done && w_fill_ok;

  // Drain side. While r_m_valid is high the drain bank is in DRAIN, so an
  // idle output with a DRAIN bank means it entered DRAIN last cycle.
  assign w_fire       = r_m_valid && bus.m_ready;
  assign w_last_fire  = w_fire && r_m_last;
  assign w_chain      = w_last_fire && (w_state[~r_drain_sel] == ST_FULL);
  assign w_idle_start = !r_m_valid && (w_state[r_drain_sel] == ST_FULL);
  assign w_idle_load  = !r_m_valid && (w_state[r_drain_sel] == ST_DRAIN);

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic w_is_fill;
    logic w_is_drain;

    assign w_is_fill  = (r_fill_sel  == 1'(gi));
    assign w_is_drain = (r_drain_sel == 1'(gi));

    assign w_bank_wr[gi]     = w_wr_accept && w_is_fill;
    assign w_bank_close[gi]  = w_close     && w_is_fill;
    // A chained start targets the bank that is not currently draining.
    assign w_bank_dstart[gi] = (w_idle_start && w_is_drain) || (w_chain && !w_is_drain);
    assign w_bank_dend[gi]   = w_last_fire && w_is_drain;
    // The waiting bank is parked on blade 0 so it can be loaded with no bubble.
    assign w_rd_addr[gi]     = w_is_drain ? r_beat : '0;

    gapu_result_bank u_bank (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_wr_en          (w_bank_wr[gi]),
      .i_wr_addr        (bus.wr_addr),
      .i_wr_data        (bus.wr_data),
      .i_wr_done        (w_bank_close[gi]),
      .i_drain_start    (w_bank_dstart[gi]),
      .i_drain_end      (w_bank_dend[gi]),
      .i_rd_addr        (w_rd_addr[gi]),
      .o_state          (w_state[gi]),
      .o_close_complete (w_close_complete[gi]),
      .o_rd_data        (w_rd_data[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_sel       <= 1'b0;
      r_drain_sel      <= 1'b0;
      r_beat           <= '0;
      r_m_valid        <= 1'b0;
      r_m_data         <= '0;
      r_m_blade        <= '0;
      r_m_last         <= 1'b0;
      r_err_incomplete <= 1'b0;
      r_err_overflow   <= 1'b0;
    end else begin
      if (w_close) begin
        r_fill_sel <= ~r_fill_sel;
      end

      if ((bus.wr_en || bus.wr_done) && !w_fill_ok) begin
        r_err_overflow <= 1'b1;
      end
      if (w_close && !w_close_complete[r_fill_sel]) begin
        r_err_incomplete <= 1'b1;
      end

      if (w_idle_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_rd_data[r_drain_sel];
        r_m_blade <= '0;
        r_m_last  <= 1'b0;
        r_beat    <= BLADE_W'(1);
      end else if (w_last_fire) begin
        r_drain_sel <= ~r_drain_sel;
        if (w_chain) begin
          // back-to-back products: blade 0 of the other bank follows at once
          r_m_valid <= 1'b1;
          r_m_data  <= w_rd_data[~r_drain_sel];
          r_m_blade <= '0;
          r_m_last  <= 1'b0;
          r_beat    <= BLADE_W'(1);
        end else begin
          r_m_valid <= 1'b0;
          r_beat    <= '0;
        end
      end else if (w_fire) begin
        r_m_data  <= w_rd_data[r_drain_sel];
        r_m_blade <= r_beat;
        r_m_last  <= (r_beat == BLADE_W'(GA_DIM - 1));
        r_beat    <= r_beat + BLADE_W'(1);
      end
    end
  end

  assign bus.wr_ready       = w_fill_ok;
  assign bus.m_valid        = r_m_valid;
  assign bus.m_data         = r_m_data;
  assign bus.m_blade        = r_m_blade;
  assign bus.m_last         = r_m_last;
  assign bus.err_incomplete = r_err_incomplete;
  assign bus.err_overflow   = r_err_overflow;

endmodule

// File: tb/tb_gapu_result_drain.sv
// -----------------------------------------------------------------------------
// tb_gapu_result_drain
// Directed bench for gapu_result_drain: full product, backpressure,
// ping-pong, incomplete/duplicate product, overflow, reset mid-drain and an
// empty product. Expected values are written out by hand per step.
// -----------------------------------------------------------------------------
module tb_gapu_result_drain;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_beat [64];

  gapu_result_drain_if bus ();

  gapu_result_drain dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d, input logic done);
    bus.wr_en   = en;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_done = done;
    step();
    bus.wr_en   = 1'b0;
    bus.wr_done = 1'b0;
  endtask

  // Expects n gapless beats starting now, m_ready held high, then idle.
  task automatic run_drain(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s valid%0d", tag, i), 32'(bus.m_valid), 32'd1);
      chk($sformatf("%s blade%0d", tag, i), 32'(bus.m_blade), 32'(i % 32));
      chk($sformatf("%s data%0d", tag, i), bus.m_data, exp_beat[i]);
      chk($sformatf("%s last%0d", tag, i), 32'(bus.m_last), 32'((i % 32) == 31));
      step();
    end
    chk($sformatf("%s idle", tag), 32'(bus.m_valid), 32'd0);
  endtask

  initial begin
    int k;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_done = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // ---- reset state
    chk("rst wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst m_data", bus.m_data, 32'd0);
    chk("rst m_blade", 32'(bus.m_blade), 32'd0);
    chk("rst m_last", 32'(bus.m_last), 32'd0);
    chk("rst err_inc", 32'(bus.err_incomplete), 32'd0);
    chk("rst err_ovf", 32'(bus.err_overflow), 32'd0);

    // ---- full product, sink always ready, 2-cycle latency
    bus.m_ready = 1'b1;
    for (int i = 0; i < 32; i++) wr(1'b1, 5'(i), 32'h3F80_0000 + 32'(i), 1'b0);
    wr(1'b0, 5'd0, 32'd0, 1'b1);
    chk("full lat0", 32'(bus.m_valid), 32'd0);
    step();
    chk("full lat1", 32'(bus.m_valid), 32'd0);
    step();
    for (int i = 0; i < 32; i++) exp_beat[i] = 32'h3F80_0000 + 32'(i);
    run_drain(32, "full");
    chk("full err_inc", 32'(bus.err_incomplete), 32'd0);
    chk("full err_ovf", 32'(bus.err_overflow), 32'd0);

    // ---- backpressure: m_ready pattern 1,0,0 repeating
    bus.m_ready = 1'b0;
    for (int i = 0; i < 32; i++) wr(1'b1, 5'(i), 32'h4000_0000 + 32'(i), 1'b0);
    wr(1'b0, 5'd0, 32'd0, 1'b1);
    k = 0;
    for (int c = 0; c < 200 && k < 32; c++) begin
      bus.m_ready = ((c % 3) == 0);
      if (bus.m_valid) begin
        chk($sformatf("bp blade%0d", k), 32'(bus.m_blade), 32'(k));
        chk($sformatf("bp data%0d", k), bus.m_data, 32'h4000_0000 + 32'(k));
        chk($sformatf("bp last%0d", k), 32'(bus.m_last), 32'(k == 31));
        if (bus.m_ready) k++;
      end
      step();
    end
    chk("bp beats", 32'(k), 32'd32);
    bus.m_ready = 1'b1;
    step();
    chk("bp idle", 32'(bus.m_valid), 32'd0);

    // ---- ping-pong: B written while A drains, 64 gapless beats
    for (int i = 0; i < 32; i++) wr(1'b1, 5'(i), 32'h4100_0000 + 32'(i), i == 31);
    for (int c = 0; c < 68; c++) begin
      if (c < 32) chk($sformatf("pp wr_ready c%0d", c), 32'(bus.wr_ready), 32'd1);
      if (c == 32 || c == 33) chk($sformatf("pp wr_ready c%0d", c), 32'(bus.wr_ready), 32'd0);
      if (c == 34) chk("pp wr_ready freed", 32'(bus.wr_ready), 32'd1);
      chk($sformatf("pp valid c%0d", c), 32'(bus.m_valid), 32'(c >= 2 && c <= 65));
      if (c >= 2 && c <= 65) begin
        chk($sformatf("pp blade c%0d", c), 32'(bus.m_blade), 32'((c - 2) % 32));
        chk($sformatf("pp data c%0d", c), bus.m_data,
            (c < 34) ? 32'h4100_0000 + 32'(c - 2) : 32'h4200_0000 + 32'(c - 34));
        chk($sformatf("pp last c%0d", c), 32'(bus.m_last), 32'(c == 33 || c == 65));
      end
      bus.wr_en   = (c < 32);
      bus.wr_addr = 5'(c);
      bus.wr_data = 32'h4200_0000 + 32'(c);
      bus.wr_done = (c == 31);
      step();
    end
    bus.wr_en   = 1'b0;
    bus.wr_done = 1'b0;

    // ---- incomplete + duplicate: blades 0..30, blade 5 rewritten
    chk("inc before", 32'(bus.err_incomplete), 32'd0);
    for (int i = 0; i < 31; i++) wr(1'b1, 5'(i), (i == 5) ? 32'h0000_AAAA : 32'h1000 + 32'(i), 1'b0);
    wr(1'b1, 5'd5, 32'h0000_BBBB, 1'b0);
    wr(1'b0, 5'd0, 32'd0, 1'b1);
    chk("inc flag", 32'(bus.err_incomplete), 32'd1);
    step();
    step();
    for (int i = 0; i < 32; i++) exp_beat[i] = 32'h1000 + 32'(i);
    exp_beat[5]  = 32'h0000_BBBB;
    exp_beat[31] = 32'd0;
    run_drain(32, "inc");

    // ---- overflow: both banks occupied while sink stalls
    bus.m_ready = 1'b0;
    for (int i = 0; i < 32; i++) wr(1'b1, 5'(i), 32'h5000_0000 + 32'(i), i == 31);
    for (int i = 0; i < 32; i++) wr(1'b1, 5'(i), 32'h6000_0000 + 32'(i), i == 31);
    step();
    step();
    chk("ovf wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("ovf held valid", 32'(bus.m_valid), 32'd1);
    chk("ovf held data", bus.m_data, 32'h5000_0000);
    chk("ovf before", 32'(bus.err_overflow), 32'd0);
    wr(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
    chk("ovf flag", 32'(bus.err_overflow), 32'd1);
    chk("ovf wr_ready after", 32'(bus.wr_ready), 32'd0);
    for (int i = 0; i < 64; i++)
      exp_beat[i] = (i < 32) ? 32'h5000_0000 + 32'(i) : 32'h6000_0000 + 32'(i - 32);
    bus.m_ready = 1'b1;
    run_drain(64, "ovf");

    // ---- reset at beat 10
    for (int i = 0; i < 32; i++) wr(1'b1, 5'(i), 32'h7000_0000 + 32'(i), i == 31);
    repeat (12) step();
    chk("rstd beat10 blade", 32'(bus.m_blade), 32'd10);
    chk("rstd beat10 data", bus.m_data, 32'h7000_000A);
    rst_n = 1'b0;
    #1;
    chk("rstd m_valid", 32'(bus.m_valid), 32'd0);
    chk("rstd wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rstd err_inc", 32'(bus.err_incomplete), 32'd0);
    chk("rstd err_ovf", 32'(bus.err_overflow), 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("rstd quiet c%0d", c), 32'(bus.m_valid), 32'd0);
      step();
    end

    // ---- empty product: 32 zero beats and err_incomplete
    wr(1'b0, 5'd0, 32'd0, 1'b1);
    chk("empty lat0", 32'(bus.m_valid), 32'd0);
    chk("empty err_inc", 32'(bus.err_incomplete), 32'd1);
    step();
    step();
    for (int i = 0; i < 32; i++) exp_beat[i] = 32'd0;
    run_drain(32, "empty");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
